// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding, packed command
// layout and the issue/wait/hold state machine encoding.
package alu_seq_pkg;

    localparam int DATA_W   = 4;
    localparam int OP_W     = 3;
    localparam int RES_W    = 8;
    localparam int CMD_W    = OP_W + 2 * DATA_W;
    localparam int CMD_A_LSB  = 0;
    localparam int CMD_B_LSB  = CMD_A_LSB + DATA_W;
    localparam int CMD_OP_LSB = CMD_B_LSB + DATA_W;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHR = 3'd6,
        OP_SHL = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e             op;
        logic [DATA_W-1:0]   b;
        logic [DATA_W-1:0]   a;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    // The ALU core takes its two operands packed as {b, a}.
    function automatic logic [2*DATA_W-1:0] cmd_operand(input cmd_t c);
        return {c.b, c.a};
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data_o while
// the FIFO is non-empty, so a pop consumes the value presented in that cycle.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem[rd_ptr_q];

    // Guard internally so a careless caller cannot overrun or underrun.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 4-bit ALU core: queues commands, issues one at a time,
// waits ALU_LAT edges and returns the result. ALU_SEQ_FLAGS_EN adds zero/carry flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CMD_W-1:0]              in_cmd,
    output logic [2*DATA_W-1:0]           alu_operand,
    output logic [OP_W-1:0]               alu_op,
    input  logic [RES_W-1:0]              alu_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RES_W-1:0]              out_result,
    output logic [OP_W-1:0]               out_op,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                          out_zero,
    output logic                          out_carry,
`endif
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0]     fifo_rd_data;
    logic [CNT_W-1:0]     fifo_count_w;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    cmd_t                 head;

    seq_state_e           state_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [2*DATA_W-1:0]  alu_operand_q;
    alu_op_e              alu_op_q;
    logic                 out_valid_q;
    logic [RES_W-1:0]     out_result_q;
    alu_op_e              out_op_q;
`ifdef ALU_SEQ_FLAGS_EN
    logic                 out_zero_q;
    logic                 out_carry_q;
`endif

    assign push = in_valid && in_ready;
    assign pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign head = cmd_t'(fifo_rd_data);

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wr_data_i (in_cmd),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .count_o   (fifo_count_w),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Issue, wait out the ALU latency, then hold the result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            alu_operand_q <= '0;
            alu_op_q      <= OP_ADD;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_op_q      <= OP_ADD;
`ifdef ALU_SEQ_FLAGS_EN
            out_zero_q    <= 1'b0;
            out_carry_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_operand_q <= cmd_operand(head);
                        alu_op_q      <= head.op;
                        cnt_q         <= LAT_CNT_W'(ALU_LAT - 1);
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        out_result_q <= alu_result;
                        out_op_q     <= alu_op_q;
                        out_valid_q  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                        out_zero_q   <= (alu_result == '0);
                        out_carry_q  <= alu_result[DATA_W];
`endif
                        state_q      <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = !fifo_full;
    assign fifo_count  = fifo_count_w;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign alu_operand = alu_operand_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_op      = out_op_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign out_zero    = out_zero_q;
    assign out_carry   = out_carry_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-register ALU model and a
// result scoreboard; flag checks compile in with ALU_SEQ_FLAGS_EN.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_cmd;
    logic [7:0]  alu_operand;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [2:0]  out_op;
    logic        busy;
    logic [2:0]  fifo_count;
`ifdef ALU_SEQ_FLAGS_EN
    logic        out_zero;
    logic        out_carry;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    int   hs_cyc[$];

    alu_op_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .alu_operand (alu_operand),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
`ifdef ALU_SEQ_FLAGS_EN
        .out_zero    (out_zero),
        .out_carry   (out_carry),
`endif
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] b, input logic [3:0] a);
        case (op)
            3'd0:    return {4'b0, a} + {4'b0, b};
            3'd1:    return {4'b0, a} - {4'b0, b};
            3'd2:    return {4'b0, a & b};
            3'd3:    return {4'b0, a | b};
            3'd4:    return {4'b0, a ^ b};
            3'd5:    return ~{4'b0, a};
            3'd6:    return {5'b0, a[3:1]};
            default: return {3'b0, a, 1'b0};
        endcase
    endfunction

    // ALU core model: result is valid one edge after operands change.
    logic [7:0] alu_res_q = 8'h00;
    always @(posedge clk) alu_res_q <= alu_f(alu_op, alu_operand[7:4], alu_operand[3:0]);
    assign alu_result = alu_res_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every accepted result against the oldest pushed command.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: observed 0x%0h expected none", out_result);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] result op=%0d res=0x%02h exp op=%0d res=0x%02h", out_op, out_result, e.op, e.res);
                check("sb_result", 32'(out_result), 32'(e.res));
                check("sb_op", 32'(out_op), 32'(e.op));
`ifdef ALU_SEQ_FLAGS_EN
                check("sb_zero", 32'(out_zero), 32'(e.res == 8'h00));
                check("sb_carry", 32'(out_carry), 32'(e.res[4]));
`endif
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [3:0] b, input logic [3:0] a, input logic [7:0] res);
        int i;
        i = 0;
        while (!in_ready && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_cmd   = {op, b, a};
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{op: op, res: res});
        $display("[TB] push op=%0d b=0x%0h a=0x%0h exp=0x%02h", op, b, a, res);
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!out_valid && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((busy || out_valid || sb.size() != 0) && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_alu_operand"}, 32'(alu_operand), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_result"}, 32'(out_result), 32'd0);
        check({tag, "_out_op"}, 32'(out_op), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_out_zero"}, 32'(out_zero), 32'd0);
        check({tag, "_out_carry"}, 32'(out_carry), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_exp [6];
        b2b_exp = '{8'h02, 8'h0E, 8'h0C, 8'hF5, 8'h05, 8'h14};

        rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add: pop one edge after push, result two edges after that.
        push_cmd(3'd0, 4'd5, 4'd3, 8'h08);
        check("add_count_after_push", 32'(fifo_count), 32'd1);
        @(posedge clk); #1;
        check("add_alu_operand", 32'(alu_operand), 32'h53);
        check("add_alu_op", 32'(alu_op), 32'd0);
        check("add_valid_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("add_valid_e2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("add_valid_e3", 32'(out_valid), 32'd1);
        check("add_out_result", 32'(out_result), 32'h08);
        check("add_out_op", 32'(out_op), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("add_valid_cleared", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Subtract underflow.
        push_cmd(3'd1, 4'd5, 4'd3, 8'hFE);
        wait_valid();
        check("sub_out_result", 32'(out_result), 32'hFE);
`ifdef ALU_SEQ_FLAGS_EN
        check("sub_zero", 32'(out_zero), 32'd0);
        check("sub_carry", 32'(out_carry), 32'd1);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Backpressure: five pushes fill the FIFO behind a held result.
        for (int k = 0; k < 5; k++) begin
            push_cmd(3'(k), 4'd2, 4'(k + 1), alu_f(3'(k), 4'd2, 4'(k + 1)));
        end
        check("bp_fifo_count", 32'(fifo_count), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(out_result), 32'(sb[0].res));
            check("bp_hold_op", 32'(out_op), 32'(sb[0].op));
        end
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back with out_ready held high: one result every four cycles.
        hs_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            push_cmd(3'(k + 2), 4'h6, 4'hA, b2b_exp[k]);
        end
        wait_drain();
        check("b2b_count", 32'(hs_cyc.size()), 32'd6);
        for (int k = 1; k < hs_cyc.size(); k++) begin
            check("b2b_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd4);
        end
        check("b2b_operand_held", 32'(alu_operand), 32'h6A);
        check("b2b_op_held", 32'(alu_op), 32'd7);

        // Simultaneous push and pop at fifo_count == 2.
        out_ready = 1'b0;
        push_cmd(3'd0, 4'd1, 4'd1, 8'h02);
        push_cmd(3'd3, 4'h3, 4'hC, 8'h0F);
        push_cmd(3'd4, 4'hF, 4'h5, 8'h0A);
        wait_valid();
        check("pp_count_before", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pp_idle_valid", 32'(out_valid), 32'd0);
        push_cmd(3'd7, 4'h0, 4'h9, 8'h12);
        check("pp_count_after", 32'(fifo_count), 32'd2);
        check("pp_issued_operand", 32'(alu_operand), 32'h3C);
        out_ready = 1'b1;
        wait_drain();

        // Reset during WAIT with three commands queued.
        out_ready = 1'b0;
        push_cmd(3'd0, 4'd1, 4'd2, 8'h03);
        push_cmd(3'd0, 4'd2, 4'd2, 8'h04);
        push_cmd(3'd0, 4'd3, 4'd2, 8'h05);
        push_cmd(3'd0, 4'd4, 4'd2, 8'h06);
        wait_valid();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_cmd(3'd0, 4'd5, 4'd2, 8'h07);
        check("rst_pre_count", 32'(fifo_count), 32'd3);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
        push_cmd(3'd7, 4'd0, 4'hF, 8'h1E);
        wait_valid();
        check("post_rst_result", 32'(out_result), 32'h1E);
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end for the 4-bit ALU core. Accepts packed {opcode, B, A} commands over a valid/ready interface and buffers them in a small FIFO. Drives them one at a time onto the ALU core's operand/opcode inputs, waits a fixed ALU latency, and returns the captured 8-bit result with its opcode over a second valid/ready interface. Sits directly upstream of the ALU core and also collects its result.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- ALU_LAT, 2: clk edges from operand/opcode update to a valid ALU result; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  command offered
- in_ready  out  1  FIFO can accept
- in_cmd  in  11  {op[2:0], b[3:0], a[3:0]}
- alu_operand  out  8  {b, a}, to ALU core operand input
- alu_op  out  3  to ALU core opcode select
- alu_result  in  8  ALU core output Y
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  8  captured ALU result
- out_op  out  3  opcode that produced out_result
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- out_zero, out_carry  out  1 each  only with ALU_SEQ_FLAGS_EN

## Operation
- Reset values: in_ready=1, alu_operand=0, alu_op=0, out_valid=0, out_result=0, out_op=0, busy=0, fifo_count=0, flags=0.
- Push: in_valid && in_ready at posedge. in_ready = (fifo_count != FIFO_DEPTH); there is no bypass when full.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE → WAIT when the FIFO is non-empty. Pop the head, load alu_operand/alu_op, and load cnt=ALU_LAT-1.
  - WAIT: decrement cnt. At cnt==0, capture alu_result→out_result and issued op→out_op, set out_valid, and go to HOLD.
  - HOLD: on out_ready, clear out_valid and go to IDLE.
- alu_operand/alu_op hold the last issued values between commands; they are never cleared except by reset.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- out_result/out_op stay stable while out_valid && !out_ready.
- Reset mid-operation: FIFO contents and any in-flight command are discarded. FSM returns to IDLE and all outputs go to their reset values.

## Timing
- Issue: alu_operand/alu_op change on the edge that pops (edge E0).
- Capture: alu_result is sampled on edge E0+ALU_LAT. out_valid rises at that edge.
- Handshake: out_valid && out_ready at edge Eh → IDLE. The next pop is at Eh+1 at the earliest.
- Throughput: one command per ALU_LAT+2 cycles when out_ready is held high.
- Command latency from push (empty FIFO, FSM in IDLE): pop 1 edge after push, out_valid ALU_LAT edges after that.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - out_zero = (captured result == 0).
  - out_carry = captured result[4], meaningful for add/sub.
  - Both are registered alongside out_result with the same timing and reset value.
- ALU_SEQ_FLAGS_EN undefined: the out_zero/out_carry ports and their registers are absent.

## Structure
- Package alu_seq_pkg holds:
  - opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHR=6, SHL=7
  - command field widths/offsets
  - FSM state enum
- Sub-module alu_seq_fifo: synchronous FIFO, parameterised depth and width, exposing count/full/empty.

## Test plan
All tests use a bench ALU model with ALU_LAT=2.
- Single add: in_cmd={000,5,3} → alu_operand=0x53, alu_op=0. out_valid rises 3 edges after push; out_result=0x08, out_op=0.
- Subtract underflow: {001,5,3} → out_result=0xFE. With flags: out_zero=0, out_carry=1.
- Backpressure: push 5 commands with out_ready=0 → in_ready=0 once fifo_count=4. The first result is held stable on out_result. Releasing out_ready drains results in push order.
- Back-to-back with out_ready=1: ops 2..7 with a=0xA, b=0x6 → results 0x02, 0x0E, 0x0C, 0xF5, 0x05, 0x14, one every 4 cycles.
- Simultaneous push/pop at fifo_count=2 → count stays 2, no command lost or duplicated.
- rst_n low during WAIT with 3 commands queued → all outputs return to reset values immediately. No out_valid after release until a new push.
